claw_axis_lock: RTL and testbench

Command-conditioning stage between the button debouncer and the two stepper drivers of the claw game. It turns debounced button levels into latched per-axis enable and direction controls, with toggle-on/toggle-off behaviour. It blocks motion into an asserted end-of-travel limit switch, inserts a dead-time pause on direction reversal, and stops an axis after a run-length timeout. Its outputs drive the driver `en` and `dir` inputs directly.

---
 rtl/claw_pkg.sv | 30 +++
 rtl/axis_lock_fsm.sv | 134 +++++++++++++
 rtl/claw_axis_lock.sv | 85 ++++++++
 tb/tb_claw_axis_lock.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/claw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : claw_pkg
// Description : Shared definitions for the claw-game axis command stage:
//               per-axis FSM state encoding, default timing parameters and
//               the bit positions of the debounced button bus.
// Revision    : 1.0 - initial release
// ============================================================================
package claw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        BLOCKED = 2'd3
    } axis_state_e;

    localparam int unsigned DEFAULT_PAUSE_TICKS = 4;
    localparam int unsigned DEFAULT_MAX_STEPS   = 4096;

    localparam int unsigned NUM_AXES = 2;
    localparam int unsigned BTN_W    = 4;

    localparam int unsigned BTN_AXIS0_DIR = 0;
    localparam int unsigned BTN_AXIS0_EN  = 1;
    localparam int unsigned BTN_AXIS1_DIR = 2;
    localparam int unsigned BTN_AXIS1_EN  = 3;

endpackage
`default_nettype wire

// File: rtl/axis_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module      : axis_lock_fsm
// Description : One motor axis. Converts single-cycle button presses into a
//               latched enable/direction pair, with reversal dead-time,
//               forward end-of-travel blocking and run-length timeout.
// Ports       : clk, rst (async, active-low)
//               dir_press, en_press : one-cycle press strobes
//               lim_s               : synchronised forward limit switch
//               step_tick           : one-cycle motor step strobe
//               en, dir, at_limit   : registered axis controls / status
//               timeout             : one-cycle pulse on automatic stop
// Revision    : 1.0 - initial release
// ============================================================================
module axis_lock_fsm
    import claw_pkg::*;
#(
    parameter int unsigned PAUSE_TICKS = DEFAULT_PAUSE_TICKS,
    parameter int unsigned MAX_STEPS   = DEFAULT_MAX_STEPS
) (
    input  logic clk,
    input  logic rst,
    input  logic dir_press,
    input  logic en_press,
    input  logic lim_s,
    input  logic step_tick,
    output logic en,
    output logic dir,
    output logic at_limit,
    output logic timeout
);

    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
    localparam int unsigned PAUSE_W = $clog2(PAUSE_TICKS + 1);
    localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(MAX_STEPS);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_TICKS);

    axis_state_e        state_q, state_d;
    logic               dir_q, dir_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic               timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            step_q    <= '0;
            pause_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            pause_q   <= pause_d;
            timeout_q <= timeout_d;
        end
    end

    // The direction toggle is resolved first; every decision below that
    // looks at direction uses the post-toggle value in dir_d.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q ^ dir_press;
        step_d    = step_q;
        pause_d   = pause_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_press) begin
                    if (lim_s && dir_d) begin
                        state_d = BLOCKED;
                    end else begin
                        state_d = RUN;
                        step_d  = '0;
                    end
                end
            end

            RUN: begin
                if (step_tick && (step_q != STEP_MAX)) begin
                    step_d = step_q + STEP_W'(1);
                end
                if (en_press) begin
                    state_d = IDLE;
                end else if (lim_s && dir_d) begin
                    state_d = BLOCKED;
                end else if (dir_press) begin
                    state_d = PAUSE;
                    pause_d = PAUSE_LOAD;
                end else if (step_d == STEP_MAX) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end

            PAUSE: begin
                if (step_tick && (pause_q != '0)) begin
                    pause_d = pause_q - PAUSE_W'(1);
                end
                if (en_press) begin
                    state_d = IDLE;
                end else if (pause_d == '0) begin
                    // Leave on the strobe that exhausts the dead-time.
                    state_d = (lim_s && dir_d) ? BLOCKED : RUN;
                    step_d  = '0;
                end
            end

            BLOCKED: begin
                // Only a reversal away from the limit restarts motion; the
                // switch releasing on its own does not.
                if (en_press) begin
                    state_d = IDLE;
                end else if (dir_press && !dir_d) begin
                    state_d = RUN;
                    step_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign en       = (state_q == RUN);
    assign dir      = dir_q;
    assign at_limit = (state_q == BLOCKED);
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: rtl/claw_axis_lock.sv
`default_nettype none
// ============================================================================
// Module      : claw_axis_lock
// Description : Command-conditioning stage between the button debouncer and
//               the two stepper drivers. Owns button edge detection and the
//               limit-switch synchronisers; each axis is an axis_lock_fsm.
// Ports       : clk, rst (async, active-low)
//               btn[3:0]            : debounced levels {en1,dir1,en0,dir0}
//               limit_switches[1:0] : raw forward end-of-travel switches
//               step_tick           : one-cycle motor step strobe
//               en, dir, at_limit, timeout [1:0] : per-axis outputs
// Revision    : 1.0 - initial release
// ============================================================================
module claw_axis_lock
    import claw_pkg::*;
#(
    parameter int unsigned PAUSE_TICKS = DEFAULT_PAUSE_TICKS,
    parameter int unsigned MAX_STEPS   = DEFAULT_MAX_STEPS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BTN_W-1:0]    btn,
    input  logic [NUM_AXES-1:0] limit_switches,
    input  logic                step_tick,
    output logic [NUM_AXES-1:0] en,
    output logic [NUM_AXES-1:0] dir,
    output logic [NUM_AXES-1:0] at_limit,
    output logic [NUM_AXES-1:0] timeout
);

    logic [BTN_W-1:0]    btn_q;
    logic [BTN_W-1:0]    press;
    logic [NUM_AXES-1:0] lim_meta;
    logic [NUM_AXES-1:0] lim_s;

    // btn_q resets low so a button held through reset release registers as
    // a press on the first clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q    <= '0;
            lim_meta <= '0;
            lim_s    <= '0;
        end else begin
            btn_q    <= btn;
            lim_meta <= limit_switches;
            lim_s    <= lim_meta;
        end
    end

    assign press = btn & ~btn_q;

    axis_lock_fsm #(
        .PAUSE_TICKS (PAUSE_TICKS),
        .MAX_STEPS   (MAX_STEPS)
    ) u_axis0 (
        .clk       (clk),
        .rst       (rst),
        .dir_press (press[BTN_AXIS0_DIR]),
        .en_press  (press[BTN_AXIS0_EN]),
        .lim_s     (lim_s[0]),
        .step_tick (step_tick),
        .en        (en[0]),
        .dir       (dir[0]),
        .at_limit  (at_limit[0]),
        .timeout   (timeout[0])
    );

    axis_lock_fsm #(
        .PAUSE_TICKS (PAUSE_TICKS),
        .MAX_STEPS   (MAX_STEPS)
    ) u_axis1 (
        .clk       (clk),
        .rst       (rst),
        .dir_press (press[BTN_AXIS1_DIR]),
        .en_press  (press[BTN_AXIS1_EN]),
        .lim_s     (lim_s[1]),
        .step_tick (step_tick),
        .en        (en[1]),
        .dir       (dir[1]),
        .at_limit  (at_limit[1]),
        .timeout   (timeout[1])
    );

endmodule
`default_nettype wire

// File: tb/tb_claw_axis_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_claw_axis_lock
// Description : Self-checking bench for claw_axis_lock. A behavioural model
//               of both axes tracks running/paused/blocked flags with plain
//               counters; outputs are compared every cycle, and directed
//               scenarios pin known literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_claw_axis_lock;

    localparam int unsigned PT  = 4;
    localparam int unsigned MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] limit_switches;
    logic       step_tick;
    logic [1:0] en, dir, at_limit, timeout;

    claw_axis_lock #(
        .PAUSE_TICKS (PT),
        .MAX_STEPS   (MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn            (btn),
        .limit_switches (limit_switches),
        .step_tick      (step_tick),
        .en             (en),
        .dir            (dir),
        .at_limit       (at_limit),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // ---------------- behavioural model ----------------
    bit m_dir[2], m_run[2], m_pause[2], m_block[2], m_to[2];
    int m_ran[2], m_wait[2];
    bit [3:0] b_prev;
    bit [1:0] l_d1, l_d2;

    task automatic model_axis(input int a, input bit pd, input bit pe,
                              input bit lim, input bit st);
        bit nd;
        nd = m_dir[a] ^ pd;
        m_to[a] = 1'b0;
        if (m_run[a]) begin
            if (st && m_ran[a] < MAX) m_ran[a]++;
            if (pe) m_run[a] = 1'b0;
            else if (lim && nd) begin m_run[a] = 1'b0; m_block[a] = 1'b1; end
            else if (pd) begin m_run[a] = 1'b0; m_pause[a] = 1'b1; m_wait[a] = PT; end
            else if (m_ran[a] == MAX) begin m_run[a] = 1'b0; m_to[a] = 1'b1; end
        end else if (m_pause[a]) begin
            if (st && m_wait[a] > 0) m_wait[a]--;
            if (pe) m_pause[a] = 1'b0;
            else if (m_wait[a] == 0) begin
                m_pause[a] = 1'b0;
                if (lim && nd) m_block[a] = 1'b1;
                else begin m_run[a] = 1'b1; m_ran[a] = 0; end
            end
        end else if (m_block[a]) begin
            if (pe) m_block[a] = 1'b0;
            else if (pd && !nd) begin m_block[a] = 1'b0; m_run[a] = 1'b1; m_ran[a] = 0; end
        end else if (pe) begin
            if (lim && nd) m_block[a] = 1'b1;
            else begin m_run[a] = 1'b1; m_ran[a] = 0; end
        end
        m_dir[a] = nd;
    endtask

    initial begin
        bit [3:0] pr;
        bit [1:0] lu;
        bit       st;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int a = 0; a < 2; a++) begin
                    m_dir[a] = 0; m_run[a] = 0; m_pause[a] = 0; m_block[a] = 0;
                    m_to[a] = 0; m_ran[a] = 0; m_wait[a] = 0;
                end
                b_prev = '0; l_d1 = '0; l_d2 = '0;
            end else begin
                pr = btn & ~b_prev;
                lu = l_d2;
                st = step_tick;
                b_prev = btn;
                l_d2 = l_d1;
                l_d1 = limit_switches;
                for (int a = 0; a < 2; a++)
                    model_axis(a, pr[2*a], pr[2*a+1], lu[a], st);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (checking) begin
                exp = {m_to[1], m_to[0], m_block[1], m_block[0],
                       m_dir[1], m_dir[0], m_run[1], m_run[0]};
                check("model_cmp{to,lim,dir,en}", {timeout, at_limit, dir, en}, exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; btn = '0; limit_switches = '0; step_tick = 1'b0;
        repeat (3) step();
        checking = 1'b1;
        check("reset_outputs", {timeout, at_limit, dir, en}, 8'h00);
        rst = 1'b1;
        step();

        // Toggle on/off
        btn[1] = 1'b1;
        check("en0_before_edge", {7'd0, en[0]}, 8'd0);
        step();
        check("en0_toggle_on", {7'd0, en[0]}, 8'd1);
        repeat (9) step();
        btn[1] = 1'b0;
        check("en0_held_dir0", {6'd0, dir[0], en[0]}, 8'd1);
        repeat (2) step();
        btn[1] = 1'b1;
        step();
        check("en0_toggle_off", {6'd0, dir[0], en[0]}, 8'd0);
        repeat (9) step();
        btn[1] = 1'b0;
        step();

        // Reversal pause
        btn[1] = 1'b1; step(); btn[1] = 1'b0;
        check("en0_restart", {7'd0, en[0]}, 8'd1);
        step();
        btn[0] = 1'b1;
        step();
        btn[0] = 1'b0;
        check("rev_dir_flip_en_low", {6'd0, dir[0], en[0]}, 8'b10);
        for (int k = 1; k <= 4; k++) begin
            step_tick = 1'b1;
            step();
            step_tick = 1'b0;
            check("pause_tick_en0", {7'd0, en[0]}, (k == 4) ? 8'd1 : 8'd0);
            step();
        end

        // Forward limit while running forward
        limit_switches[0] = 1'b1;
        step(); step();
        check("limit_not_yet", {6'd0, at_limit[0], en[0]}, 8'b01);
        step();
        check("limit_blocked", {6'd0, at_limit[0], en[0]}, 8'b10);
        btn[0] = 1'b1;
        step();
        check("limit_reverse_run", {5'd0, at_limit[0], dir[0], en[0]}, 8'b001);
        btn[0] = 1'b0; limit_switches[0] = 1'b0;
        step();

        // Timeout on axis0; axis1 started later so it keeps running
        for (int k = 1; k <= 3; k++) begin
            step_tick = 1'b1; step(); step_tick = 1'b0; step();
        end
        btn[3] = 1'b1; step(); btn[3] = 1'b0;
        check("en1_start", {7'd0, en[1]}, 8'd1);
        step();
        for (int k = 4; k <= 8; k++) begin
            step_tick = 1'b1;
            step();
            step_tick = 1'b0;
            if (k == 8)
                check("timeout_hit{to0,en0,en1,to1}", {4'd0, timeout[0], en[0], en[1], timeout[1]}, 8'b1010);
            else
                check("before_timeout{to0,en0}", {6'd0, timeout[0], en[0]}, 8'b01);
            step();
        end
        check("timeout_single_cycle", {6'd0, timeout[0], en[0]}, 8'b00);
        btn[3] = 1'b1; step(); btn[3] = 1'b0;
        check("en1_stop", {6'd0, timeout[1], en[1]}, 8'd0);
        step();

        // Start into limit on axis1
        limit_switches[1] = 1'b1;
        repeat (3) step();
        btn[3:2] = 2'b11;
        step();
        check("start_into_limit", {5'd0, at_limit[1], dir[1], en[1]}, 8'b110);
        repeat (3) step();
        btn[3:2] = 2'b00;
        check("still_blocked", {6'd0, at_limit[1], en[1]}, 8'b10);
        step();
        btn[2] = 1'b1;
        step();
        check("axis1_reverse_run", {5'd0, at_limit[1], dir[1], en[1]}, 8'b001);
        btn[2] = 1'b0; limit_switches[1] = 1'b0;
        step();

        // Reset mid-run with both axes running
        btn[1] = 1'b1; step(); btn[1] = 1'b0;
        check("both_running", {6'd0, en}, 8'b11);
        #2 rst = 1'b0;
        #1 check("async_reset_now", {timeout, at_limit, dir, en}, 8'h00);
        step(); step();
        check("reset_held", {timeout, at_limit, dir, en}, 8'h00);
        rst = 1'b1;
        step();
        check("after_release", {timeout, at_limit, dir, en}, 8'h00);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(399) == 0) rst = 1'b0;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) btn[b] = ~btn[b];
            for (int l = 0; l < 2; l++)
                if ($urandom_range(24) == 0) limit_switches[l] = ~limit_switches[l];
            step_tick = ($urandom_range(3) == 0);
            step();
        end

        step_tick = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
